bcd_to_unsigned: RTL

Sequential reverse double-dabble converter: takes an 8-digit packed BCD word and produces its unsigned binary value with one shift-and-correct step per cycle pair. It is the inverse of the binary-to-BCD display path. Typical use is converting user-entered BCD time and alarm fields back to binary counts for the clock core. It uses the same `trigger`/`idle` handshake as the binary-to-BCD converter, so both can share one controller.

---
 rtl/bcd_to_unsigned.sv | 94 +++++++++
 1 files changed

// File: rtl/bcd_to_unsigned.sv
// Sequential reverse double-dabble: 8-digit packed BCD in, unsigned binary out.
// state   | meaning
// S_IDLE  | waiting for trigger; bin/error hold the last result
// S_SHIFT | shift {work,acc} right by one; the 32nd shift completes the conversion
// S_SUB3  | subtract 3 from every work nibble that is >= 8
module bcd_to_unsigned #(
  parameter int N_DIGITS = 8,
  parameter int BIN_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic                  idle,
  output logic [BIN_W-1:0]      bin,
  output logic                  error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_SUB3  = 2'b10
  } state_t;

  localparam logic [5:0] LAST_SHIFT = 6'(BIN_W - 1);

  state_t                state, state_next;
  logic [4*N_DIGITS-1:0] work, work_adj;
  logic [BIN_W-1:0]      acc;
  logic [5:0]            cnt;
  logic                  err_l;
  logic                  bad_digit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE:  state_next = trigger ? S_SHIFT : S_IDLE;
      S_SHIFT: state_next = (cnt == LAST_SHIFT) ? S_IDLE : S_SUB3;
      S_SUB3:  state_next = S_SHIFT;
      default: state_next = S_IDLE;
    endcase
  end

  assign idle = (state == S_IDLE);

  // Per-nibble checks are independent; no borrow ever crosses a nibble boundary.
  always_comb begin
    bad_digit = 1'b0;
    work_adj  = work;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      if (work[4*i +: 4] >= 4'd8) work_adj[4*i +: 4] = work[4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work  <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_l <= 1'b0;
      bin   <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trigger) begin
            work  <= bcd;
            acc   <= '0;
            cnt   <= '0;
            err_l <= bad_digit;
          end
        end
        S_SHIFT: begin
          work <= {1'b0, work[4*N_DIGITS-1:1]};
          acc  <= {work[0], acc[BIN_W-1:1]};
          cnt  <= cnt + 6'd1;
          if (cnt == LAST_SHIFT) begin
            bin   <= err_l ? '0 : {work[0], acc[BIN_W-1:1]};
            error <= err_l;
          end
        end
        S_SUB3: work <= work_adj;
        default: ;
      endcase
    end
  end

endmodule
